// File: rtl/grid_accum.sv
// ---------------------------------------------------------------------------
// grid_accum
//
// Receiving end of the gridder output stream. (grid_index, result) pairs are
// accumulated into an on-chip grid RAM by read-modify-write. An end-of-frame
// marker (in_last) causes the whole grid to be streamed out and cleared.
// Each word is packed complex fixed point: re = [DATA_W-1:DATA_W/2],
// im = [DATA_W/2-1:0], both signed.
//
// Optional build macro:
//   GRID_ACCUM_SAT_EN  defined   -> each half saturates on signed overflow
//                      undefined -> each half wraps two's-complement
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample (high only in ACCUM)
//   in_index   grid cell address of the sample
//   in_data    sample value {re, im}
//   in_last    final sample of the frame, qualified by in_valid
//   out_valid  dump word valid
//   out_ready  downstream accepts dump word
//   out_index  cell address of out_data
//   out_data   accumulated cell value {re, im}
//   out_last   high with the final cell (index 2**IDX_W-1)
//   n_accum    samples accepted since the last dump (wraps at 2**32)
//   busy       high in any state other than ACCUM
// ---------------------------------------------------------------------------
module grid_accum #(
    parameter int IDX_W  = 14,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [31:0]       n_accum,
    output logic              busy
);

    localparam int               HALF_W   = DATA_W / 2;
    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_DUMP
    } state_t;

    // Add one signed half; optionally clamp on signed overflow.
    function automatic logic [HALF_W-1:0] add_half(input logic [HALF_W-1:0] a,
                                                   input logic [HALF_W-1:0] b);
        logic [HALF_W-1:0] s;
        s = a + b;
`ifdef GRID_ACCUM_SAT_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((a[HALF_W-1] == b[HALF_W-1]) && (s[HALF_W-1] != a[HALF_W-1])) begin
            s = a[HALF_W-1] ? {1'b1, {(HALF_W-1){1'b0}}}
                            : {1'b0, {(HALF_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // FSM / output registers
    state_t              r_state;
    logic [IDX_W-1:0]    r_clr_ptr;
    logic                r_drain_cnt;
    logic [IDX_W-1:0]    r_dump_ptr;
    logic                r_dump_fetch;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_out_valid;
    logic [IDX_W-1:0]    r_out_index;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [31:0]         r_n_accum;

    // Accumulate pipeline: stage 1 holds the sample whose RAM read is in
    // flight; the forward registers hold the value written last cycle.
    logic                r_s1_valid;
    logic [IDX_W-1:0]    r_s1_idx;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_fwd_valid;
    logic [IDX_W-1:0]    r_fwd_idx;
    logic [DATA_W-1:0]   r_fwd_data;

    // Grid RAM
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_ram_q;

    logic                w_in_fire;
    logic                w_out_fire;
    logic [DATA_W-1:0]   w_base;
    logic [DATA_W-1:0]   w_sum;
    logic                w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [IDX_W-1:0]    w_raddr;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // A read issued in the same cycle as the previous write returns the old
    // cell (read-first), so a back-to-back hit on the same cell takes the
    // freshly written sum instead.
    assign w_base = (r_fwd_valid && (r_fwd_idx == r_s1_idx)) ? r_fwd_data : r_ram_q;
    assign w_sum  = {add_half(w_base[DATA_W-1:HALF_W], r_s1_data[DATA_W-1:HALF_W]),
                     add_half(w_base[HALF_W-1:0],      r_s1_data[HALF_W-1:0])};

    // During DUMP the read port walks the grid; otherwise it follows the input.
    assign w_raddr = (r_state == ST_DUMP) ? r_dump_ptr : in_index;

    // Single write port shared by clear, accumulate and dump-clear. The three
    // sources are never active together: the pipeline is empty in CLEAR and
    // DUMP, and dump writes only happen in DUMP.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_we    = 1'b0;
        w_waddr = r_s1_idx;
        w_wdata = w_sum;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_ptr;
            w_wdata = '0;
        end else if (r_s1_valid) begin
            w_we    = 1'b1;
        end else if (w_out_fire) begin
            w_we    = 1'b1;
            w_waddr = r_out_index;
            w_wdata = '0;
        end
    end

    // NOTE: the grid RAM and its read register carry no reset; a RAM macro
    // cannot be reset in one cycle, so the CLEAR state zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_ram_q <= r_mem[w_raddr];
    end

    // Accumulate pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_data   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_idx   <= '0;
            r_fwd_data  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            r_s1_valid  <= w_in_fire;
            if (w_in_fire) begin
                r_s1_idx  <= in_index;
                r_s1_data <= in_data;
            end
            r_fwd_valid <= r_s1_valid;
            r_fwd_idx   <= r_s1_idx;
            r_fwd_data  <= w_sum;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_CLEAR;
            r_clr_ptr    <= '0;
            r_drain_cnt  <= 1'b0;
            r_dump_ptr   <= '0;
            r_dump_fetch <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_n_accum    <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + IDX_W'(1);
                    if (r_clr_ptr == LAST_IDX) begin
                        r_state    <= ST_ACCUM;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end

                ST_ACCUM: begin
                    if (w_in_fire) begin
                        r_n_accum <= r_n_accum + 32'd1;
                        if (in_last) begin
                            r_state     <= ST_DRAIN;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_drain_cnt <= 1'b0;
                        end
                    end
                end

                // Two cycles: the last sample's write lands in the first.
                ST_DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state      <= ST_DUMP;
                        r_dump_ptr   <= '0;
                        r_dump_fetch <= 1'b0;
                    end
                end

                // Per word: issue read, load output register, wait handshake.
                ST_DUMP: begin
                    if (r_out_valid) begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (r_out_last) begin
                                r_n_accum  <= '0;
                                r_state    <= ST_ACCUM;
                                r_in_ready <= 1'b1;
                                r_busy     <= 1'b0;
                            end else begin
                                r_dump_ptr <= r_dump_ptr + IDX_W'(1);
                            end
                        end
                    end else if (r_dump_fetch) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_ram_q;
                        r_out_index  <= r_dump_ptr;
                        r_out_last   <= (r_dump_ptr == LAST_IDX);
                        r_dump_fetch <= 1'b0;
                    end else begin
                        r_dump_fetch <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign n_accum   = r_n_accum;

endmodule

// File: tb/tb_grid_accum.sv
// ---------------------------------------------------------------------------
// tb_grid_accum
//
// Self-checking bench for grid_accum with a 16-cell grid. A reference model
// keeps the grid as plain re/im integer arrays and a sample counter; a
// monitor compares n_accum every cycle and every dump word against it.
// Directed frames then pin the model with hand-computed literal values.
// Inputs change 1 time unit after the rising edge; the monitor samples on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_grid_accum;

    localparam int IDX_W  = 4;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  in_index;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [31:0]       n_accum;
    logic              busy;

    always #5 clk = ~clk;

    grid_accum #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last),
        .n_accum   (n_accum),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_re [DEPTH];
    logic [31:0] m_im [DEPTH];
    logic [31:0] m_cnt;
    int          m_exp_idx;
    int          dumps_done = 0;
    logic [63:0] dump_buf [DEPTH];
    bit          rdy_rand = 1'b0;

    // Signed add of two 32-bit halves using wide arithmetic.
    function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef GRID_ACCUM_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    initial begin
        bit          prev_stall;
        logic [63:0] prev_data;
        logic [3:0]  prev_idx;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        m_cnt      = '0;
        m_exp_idx  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_re[i] = '0;
                    m_im[i] = '0;
                end
                m_cnt      = '0;
                m_exp_idx  = 0;
                prev_stall = 1'b0;
            end else begin
                check("n_accum", 64'(n_accum), 64'(m_cnt));
                if (in_valid && in_ready) begin
                    m_re[in_index] = add32(m_re[in_index], in_data[63:32]);
                    m_im[in_index] = add32(m_im[in_index], in_data[31:0]);
                    m_cnt++;
                end
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data",  out_data, prev_data);
                    check("hold_index", 64'(out_index), 64'(prev_idx));
                end
                prev_stall = 1'b0;
                if (out_valid) begin
                    check("out_index", 64'(out_index), 64'(m_exp_idx));
                    check("out_data", out_data, {m_re[m_exp_idx], m_im[m_exp_idx]});
                    check("out_last", 64'(out_last), 64'(m_exp_idx == DEPTH - 1));
                    if (out_ready) begin
                        dump_buf[m_exp_idx] = out_data;
                        m_re[m_exp_idx] = '0;
                        m_im[m_exp_idx] = '0;
                        if (m_exp_idx == DEPTH - 1) begin
                            m_exp_idx = 0;
                            m_cnt     = '0;
                            dumps_done++;
                        end else begin
                            m_exp_idx++;
                        end
                    end else begin
                        prev_stall = 1'b1;
                        prev_data  = out_data;
                        prev_idx   = out_index;
                    end
                end
            end
        end
    end

    // Downstream readiness: always ready, or random backpressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [31:0] re, input logic [31:0] im, input bit last);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_index = IDX_W'(idx);
        in_data  = {re, im};
        in_last  = last;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic clear_buf();
        for (int i = 0; i < DEPTH; i++) dump_buf[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic wait_frame(input int target);
        for (int k = 0; k < 3000 && dumps_done < target; k++) tick();
        check("frame_done", 64'(dumps_done), 64'(target));
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        check("ready_after_dump", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            tick();
            cnt++;
        end
        check("clear_cycles", 64'(cnt), 64'd16);
        check("busy_accum", 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int frames;
        bit found;
        frames   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_index = '0;
        in_data  = '0;
        in_last  = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_n_accum",   64'(n_accum),   64'd0);
        check("rst_busy",      64'(busy),      64'd1);

        @(posedge clk);
        #1 rst = 1'b1;
        wait_clear();

        // Immediate last at index 0 with zero data: 16 zero words.
        clear_buf();
        send(0, 32'd0, 32'd0, 1'b1);
        frames++;
        wait_frame(frames);
        for (int i = 0; i < DEPTH; i++) check("zero_frame", dump_buf[i], 64'd0);

        // Scattered samples
        clear_buf();
        send(3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        send(7, 32'd1, 32'd1, 1'b0);
        send(3, 32'd10, 32'd4, 1'b1);
        check("scatter_n_accum", 64'(n_accum), 64'd3);
        check("scatter_busy", 64'(busy), 64'd1);
        check("scatter_in_ready", 64'(in_ready), 64'd0);
        frames++;
        wait_frame(frames);
        check("scatter_cell3",  dump_buf[3],  {32'd15, 32'd2});
        check("scatter_cell7",  dump_buf[7],  {32'd1, 32'd1});
        check("scatter_cell0",  dump_buf[0],  64'd0);
        check("scatter_cell15", dump_buf[15], 64'd0);
        check("n_accum_cleared", 64'(n_accum), 64'd0);

        // Same-cell hazard with gaps of 0, 1 and 2 idle cycles
        for (int g = 0; g < 3; g++) begin
            clear_buf();
            for (int k = 0; k < 4; k++) begin
                send(9, 32'd1, 32'hFFFF_FFFF, k == 3);
                if (k < 3) repeat (g) tick();
            end
            frames++;
            wait_frame(frames);
            check("hazard_cell9", dump_buf[9], {32'd4, 32'hFFFF_FFFC});
            check("hazard_cell8", dump_buf[8], 64'd0);
        end

        // Dump backpressure
        rdy_rand = 1'b1;
        clear_buf();
        send(5, 32'd100, 32'hFFFF_FF9C, 1'b0);
        send(15, 32'd1, 32'd2, 1'b1);
        frames++;
        wait_frame(frames);
        check("bp_cell5",  dump_buf[5],  {32'd100, 32'hFFFF_FF9C});
        check("bp_cell15", dump_buf[15], {32'd1, 32'd2});
        rdy_rand = 1'b0;

        // Second frame starts from a cleared grid
        clear_buf();
        send(5, 32'd2, 32'd3, 1'b1);
        frames++;
        wait_frame(frames);
        check("frame2_cell5",  dump_buf[5],  {32'd2, 32'd3});
        check("frame2_cell15", dump_buf[15], 64'd0);

        // Overflow in both halves
        clear_buf();
        send(1, 32'h7FFF_FFF0, 32'h8000_0005, 1'b0);
        send(1, 32'h0000_0020, 32'hFFFF_FFF0, 1'b1);
        frames++;
        wait_frame(frames);
`ifdef GRID_ACCUM_SAT_EN
        check("ovf_cell1", dump_buf[1], {32'h7FFF_FFFF, 32'h8000_0000});
`else
        check("ovf_cell1", dump_buf[1], {32'h8000_0010, 32'h7FFF_FFF5});
`endif

        // Asynchronous reset in the middle of a dump
        send(10, 32'd7, 32'd7, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            tick();
            found = out_valid && (out_index == 4'd5);
        end
        check("reach_word5", 64'(found), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",      64'(busy),      64'd1);
        check("mid_rst_in_ready",  64'(in_ready),  64'd0);
        check("mid_rst_n_accum",   64'(n_accum),   64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_clear();
        clear_buf();
        send(0, 32'd0, 32'd0, 1'b1);
        frames++;
        wait_frame(frames);
        for (int i = 0; i < DEPTH; i++) check("post_rst_zero", dump_buf[i], 64'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grid_accum.md
Name: grid_accum

Overview:
Receiving end of the gridder output stream. Accepts (grid_index, result) pairs from the gridding top and accumulates them into an on-chip grid RAM using read-modify-write. On an end-of-frame marker it streams the whole grid out and clears it. `result` is packed complex fixed-point: re = [63:32], im = [31:0], each signed 32-bit.

Parameters:
- IDX_W, 14, grid index width; grid depth = 2**IDX_W entries.
- DATA_W, 64, word width; must be even; halves are re/im.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_index  in  IDX_W  grid cell address
- in_data  in  DATA_W  sample value {re, im}
- in_last  in  1  final sample of frame; qualified by in_valid
- out_valid  out  1  dump word valid
- out_ready  in  1  downstream accepts dump word
- out_index  out  IDX_W  cell address of out_data
- out_data  out  DATA_W  accumulated cell {re, im}
- out_last  out  1  high with final cell (index 2**IDX_W-1)
- n_accum  out  32  samples accepted since last dump
- busy  out  1  high in any state other than ACCUM

Behaviour:
- Reset (rst=0, async) values:
  - in_ready=0, out_valid=0, out_last=0, out_index=0, out_data=0, n_accum=0, busy=1.
  - State goes to CLEAR. Pipeline valids are zeroed. In-flight samples are discarded.
- States: CLEAR -> ACCUM -> DRAIN -> DUMP -> ACCUM.
- CLEAR:
  - Writes zero to every cell, one per cycle, addresses 0..2**IDX_W-1; in_ready=0.
  - Moves to ACCUM after the last address.
- ACCUM:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Each accepted sample increments n_accum. n_accum wraps at 2**32.
  - Pipeline: cycle t accept and issue RAM read (synchronous, read-first). Cycle t+1 compute sum = ram_q + in_data, write at the end of t+1. The cell is visible to reads issued at t+2.
  - Hazard: if the stage-2 index equals the stage-1 index (back-to-back same cell), stage 1 uses the stage-2 sum instead of ram_q. Consecutive same-cell samples must sum exactly.
  - re and im halves add independently. Default is wrap modulo 2**32 per half.
  - A handshake with in_last=1 accepts the sample, then drops in_ready the next cycle and moves to DRAIN.
- DRAIN:
  - Lasts 2 cycles until the pipeline write completes; in_ready=0.
- DUMP:
  - in_ready=0. Streams cells 0..2**IDX_W-1 in order on the out_* ports.
  - out_valid holds and out_data/out_index stay stable until out_ready. Stalls are allowed at any word.
  - out_data is the cell value. Each cell is written to zero in the cycle its word is handshaken.
  - out_last=1 only with the final word.
  - After the final handshake: n_accum clears to 0, then ACCUM next cycle.
- No dump without in_last. Samples are never dropped while in_ready=1.

Optional Feature:
- Macro GRID_ACCUM_SAT_EN.
- Defined: each 32-bit half saturates to 0x7FFFFFFF / 0x80000000 on signed overflow.
- Undefined: halves wrap two's-complement.
- No other behaviour differs.

Test Plan:
- Reset + clear, IDX_W=4: release rst; in_ready rises after 16 CLEAR cycles; immediate in_last at index 0 with data 0 dumps 16 zero words.
- Scattered samples: (3, {5,-2}) then (7, {1,1}) then last (3, {10,4}) -> dump cell3={15,2}, cell7={1,1}, others 0, n_accum=3 before dump.
- Back-to-back hazard: 4 consecutive samples to cell 9, each {1,-1} -> cell9={4,-4}. Repeat with gaps of 1 and 2 idle cycles; same result.
- Dump backpressure: toggle out_ready randomly; every word held stable until accepted, 16 words, out_last only on index 15. A second frame after the dump starts from zero.
- Overflow: two samples {0x7FFFFFF0, 0} plus {0x20, 0} to cell 1 -> re=0x80000010 without GRID_ACCUM_SAT_EN, 0x7FFFFFFF with it.
- Async reset mid-DUMP at word 5 -> out_valid=0 immediately, CLEAR reruns, then the grid reads all zero.
